// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_pkg
// Description : State encodings, instruction field codes and the Moore output
//               map shared by the multi-cycle sequencer and its datapath.
// Revision    : 1.0
// ============================================================================
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUPD  = 3'd6,
        S_HALT   = 3'd7
    } seq_state_t;

    // ir[7:6]
    localparam logic [1:0] MODE_JUMP  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_STORE = 2'b10;
    localparam logic [1:0] MODE_ARITH = 2'b11;

    // ir[5:4] for arithmetic instructions
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_NOP2 = 2'b11;

    typedef struct packed {
        logic imem_req;
        logic pc_write;
        logic pc_jump;
        logic register_write;
        logic memory_to_register;
        logic memory_write;
        logic alu_negation;
        logic val_b_imm_selection;
    } dp_strobes_t;

    // ctl is ir[7:4]: {mode, op}
    function automatic seq_state_t route_for(logic [3:0] ctl);
        seq_state_t v_next;
        case (ctl[3:2])
            MODE_JUMP:              v_next = S_PCUPD;
            MODE_LOAD, MODE_STORE:  v_next = S_MEM;
            default:                v_next = (ctl[1:0] == OP_ADD || ctl[1:0] == OP_SUB)
                                             ? S_EXEC : S_PCUPD;
        endcase
        return v_next;
    endfunction

    function automatic dp_strobes_t strobes_for(seq_state_t s, logic [3:0] ctl);
        dp_strobes_t v_out;
        v_out = '0;
        case (s)
            S_FETCH: v_out.imem_req = 1'b1;
            S_EXEC: begin
                v_out.register_write = 1'b1;
                v_out.alu_negation   = (ctl[1:0] == OP_SUB);
            end
            S_MEM: begin
                v_out.val_b_imm_selection = 1'b1;
                v_out.memory_write        = (ctl[3:2] == MODE_STORE);
            end
            S_WB: begin
                v_out.register_write      = 1'b1;
                v_out.memory_to_register  = 1'b1;
                v_out.val_b_imm_selection = 1'b1;
            end
            S_PCUPD: begin
                v_out.pc_jump  = (ctl[3:2] == MODE_JUMP);
                v_out.pc_write = (ctl[3:2] != MODE_JUMP);
            end
            default: v_out = '0;
        endcase
        return v_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_if
// Description : Instruction-fetch handshake plus datapath control bundle.
//               master = sequencer side, slave = memory/datapath side.
// Revision    : 1.0
// ============================================================================
interface multicycle_sequencer_if;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] ir;
    logic       pc_write;
    logic       pc_jump;
    logic       register_write;
    logic       memory_to_register;
    logic       memory_write;
    logic       alu_negation;
    logic       val_b_imm_selection;
    logic [2:0] state;
    logic [7:0] retired;
    logic       fault;

    modport master (
        output imem_req, ir, pc_write, pc_jump, register_write, memory_to_register,
               memory_write, alu_negation, val_b_imm_selection, state, retired, fault,
        input  imem_ack, imem_data
    );

    modport slave (
        input  imem_req, ir, pc_write, pc_jump, register_write, memory_to_register,
               memory_write, alu_negation, val_b_imm_selection, state, retired, fault,
        output imem_ack, imem_data
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_wait_counter
// Description : Loadable down-counter with clear and terminal-count flag,
//               shared by the fetch timeout and the load-latency wait.
// Revision    : 1.0
// ============================================================================
module multicycle_sequencer_wait_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             areset,
    input  wire logic             i_clear,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_value,
    input  wire logic             i_dec,
    output logic                  o_tc
);
    logic [WIDTH-1:0] r_count;

    // Saturates at zero so a lingering decrement cannot wrap to full scale.
    always_ff @(posedge clk) begin
        if (!areset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multi-cycle control FSM: fetch over req/ack, then step the IR
//               through DECODE/EXEC/MEM/WB/PCUPD with registered Moore strobes.
// Config      : SEQ_SINGLE_STEP_EN adds a step input; one instruction per pulse.
// Revision    : 1.0
// ============================================================================
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int DMEM_LAT       = 1,
    parameter int FETCH_WAIT_MAX = 15
) (
    input  wire logic clk,
    input  wire logic areset,
`ifdef SEQ_SINGLE_STEP_EN
    input  wire logic step,
`endif
    multicycle_sequencer_if.master bus
);
    localparam int         c_cnt_w      = 8;
    localparam logic [7:0] c_fetch_load = 8'(FETCH_WAIT_MAX - 1);
    localparam logic [7:0] c_mem_load   = 8'(DMEM_LAT - 1);
    localparam bit         c_timeout_en = (FETCH_WAIT_MAX != 0);

`ifdef SEQ_SINGLE_STEP_EN
    localparam seq_state_t c_after_pcupd = S_IDLE;
    logic w_go;
    assign w_go = step;
`else
    localparam seq_state_t c_after_pcupd = S_FETCH;
    logic w_go;
    assign w_go = 1'b1;
`endif

    seq_state_t  r_state;
    logic [7:0]  r_ir;
    dp_strobes_t r_strobes;
    logic [7:0]  r_retired;
    logic        r_fault;

    seq_state_t  w_route;
    logic        w_is_load;
    logic        w_cnt_clear;
    logic        w_cnt_load;
    logic [7:0]  w_cnt_value;
    logic        w_cnt_dec;
    logic        w_cnt_tc;

    assign w_route   = route_for(r_ir[7:4]);
    assign w_is_load = (r_ir[7:6] == MODE_LOAD);

    // The counter is armed on the edge that enters FETCH or a load's MEM phase,
    // so its terminal count lines up with the last allowed cycle in that state.
    always_comb begin
        w_cnt_clear = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_value = c_fetch_load;
        w_cnt_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_load  = w_go;
                w_cnt_clear = !w_go;
            end
            S_PCUPD:  w_cnt_load = (c_after_pcupd == S_FETCH);
            S_FETCH:  w_cnt_dec  = !bus.imem_ack;
            S_DECODE: begin
                w_cnt_load  = w_is_load;
                w_cnt_value = c_mem_load;
            end
            S_MEM:    w_cnt_dec  = w_is_load;
            default:  w_cnt_clear = 1'b0;
        endcase
    end

    multicycle_sequencer_wait_counter #(
        .WIDTH(c_cnt_w)
    ) u_wait_counter (
        .clk          (clk),
        .areset       (areset),
        .i_clear      (w_cnt_clear),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_value),
        .i_dec        (w_cnt_dec),
        .o_tc         (w_cnt_tc)
    );

    // Strobes are registered together with the state they belong to.
    always_ff @(posedge clk) begin
        if (!areset) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_strobes <= '0;
            r_retired <= '0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state   <= S_FETCH;
                        r_strobes <= strobes_for(S_FETCH, r_ir[7:4]);
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir      <= bus.imem_data;
                        r_state   <= S_DECODE;
                        r_strobes <= strobes_for(S_DECODE, bus.imem_data[7:4]);
                    end else if (c_timeout_en && w_cnt_tc) begin
                        r_state   <= S_HALT;
                        r_fault   <= 1'b1;
                        r_strobes <= strobes_for(S_HALT, r_ir[7:4]);
                    end
                end
                S_DECODE: begin
                    r_state   <= w_route;
                    r_strobes <= strobes_for(w_route, r_ir[7:4]);
                end
                S_EXEC, S_WB: begin
                    r_state   <= S_PCUPD;
                    r_strobes <= strobes_for(S_PCUPD, r_ir[7:4]);
                end
                S_MEM: begin
                    if (!w_is_load) begin
                        r_state   <= S_PCUPD;
                        r_strobes <= strobes_for(S_PCUPD, r_ir[7:4]);
                    end else if (w_cnt_tc) begin
                        r_state   <= S_WB;
                        r_strobes <= strobes_for(S_WB, r_ir[7:4]);
                    end
                end
                S_PCUPD: begin
                    r_retired <= r_retired + 8'd1;
                    r_state   <= c_after_pcupd;
                    r_strobes <= strobes_for(c_after_pcupd, r_ir[7:4]);
                end
                S_HALT: begin
                    r_state   <= S_HALT;
                    r_strobes <= '0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_strobes <= '0;
                end
            endcase
        end
    end

    assign bus.imem_req            = r_strobes.imem_req;
    assign bus.pc_write            = r_strobes.pc_write;
    assign bus.pc_jump             = r_strobes.pc_jump;
    assign bus.register_write      = r_strobes.register_write;
    assign bus.memory_to_register  = r_strobes.memory_to_register;
    assign bus.memory_write        = r_strobes.memory_write;
    assign bus.alu_negation        = r_strobes.alu_negation;
    assign bus.val_b_imm_selection = r_strobes.val_b_imm_selection;
    assign bus.ir                  = r_ir;
    assign bus.state               = r_state;
    assign bus.retired             = r_retired;
    assign bus.fault               = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Self-checking bench: per-instruction cycle schedules derived
//               from the instruction class, table vectors and random programs.
// Revision    : 1.0
// ============================================================================
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    localparam int DMEM_LAT       = 2;
    localparam int FETCH_WAIT_MAX = 15;

    // Observed strobe vector bit weights
    localparam logic [7:0] V_REQ = 8'h80;
    localparam logic [7:0] V_PCW = 8'h40;
    localparam logic [7:0] V_PCJ = 8'h20;
    localparam logic [7:0] V_RW  = 8'h10;
    localparam logic [7:0] V_M2R = 8'h08;
    localparam logic [7:0] V_MW  = 8'h04;
    localparam logic [7:0] V_NEG = 8'h02;
    localparam logic [7:0] V_IMM = 8'h01;

    typedef struct {
        logic [7:0] ins;
        int         lat;
        logic [7:0] pc_vec;
        int         rw;
        int         mw;
        int         neg;
    } vec_t;

    logic clk = 1'b0;
    logic areset = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    multicycle_sequencer_if bus();

    multicycle_sequencer #(
        .DMEM_LAT       (DMEM_LAT),
        .FETCH_WAIT_MAX (FETCH_WAIT_MAX)
    ) dut (
        .clk    (clk),
        .areset (areset),
`ifdef SEQ_SINGLE_STEP_EN
        .step   (step),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] obs;
    assign obs = {bus.imem_req, bus.pc_write, bus.pc_jump, bus.register_write,
                  bus.memory_to_register, bus.memory_write, bus.alu_negation,
                  bus.val_b_imm_selection};

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_retired;
    logic [7:0] exp_q[$];
    vec_t       tbl[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Expected per-cycle strobes from FETCH through PCUPD for one instruction.
    task automatic build_trace(input logic [7:0] ins, input int wait_cyc);
        exp_q.delete();
        for (int i = 0; i <= wait_cyc; i++) exp_q.push_back(V_REQ);
        exp_q.push_back(8'h00);
        case (ins[7:6])
            2'b00: exp_q.push_back(V_PCJ);
            2'b01: begin
                for (int i = 0; i < DMEM_LAT; i++) exp_q.push_back(V_IMM);
                exp_q.push_back(V_RW | V_M2R | V_IMM);
                exp_q.push_back(V_PCW);
            end
            2'b10: begin
                exp_q.push_back(V_MW | V_IMM);
                exp_q.push_back(V_PCW);
            end
            default: begin
                if (ins[5:4] == 2'b01) exp_q.push_back(V_RW);
                if (ins[5:4] == 2'b10) exp_q.push_back(V_RW | V_NEG);
                exp_q.push_back(V_PCW);
            end
        endcase
    endtask

    // Entered with the DUT in FETCH, before that cycle's falling edge.
    task automatic run_instr(input logic [7:0] ins, input int wait_cyc,
                             output int lat, output logic [7:0] pc_vec,
                             output int rw_n, output int mw_n, output int neg_n);
        build_trace(ins, wait_cyc);
        lat = 0; pc_vec = 8'h00; rw_n = 0; mw_n = 0; neg_n = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check("strobes", {24'h0, obs}, {24'h0, exp_q[k]});
            check("retired", {24'h0, bus.retired}, {24'h0, m_retired});
            if (k == 0) begin
                check("state_fetch", {29'h0, bus.state}, {29'h0, S_FETCH});
                check("fault_clear", {31'h0, bus.fault}, 32'h0);
            end
            if (k > wait_cyc) check("ir", {24'h0, bus.ir}, {24'h0, ins});
            if (bus.register_write) rw_n++;
            if (bus.memory_write)   mw_n++;
            if (bus.alu_negation)   neg_n++;
            if ((bus.pc_write || bus.pc_jump) && lat == 0) begin
                lat    = k - wait_cyc + 1;
                pc_vec = obs;
            end
            if (k < wait_cyc) begin
                bus.imem_ack  = 1'b0;
                bus.imem_data = 8'($urandom);
            end else if (k == wait_cyc) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = ins;
            end else begin
                bus.imem_ack  = 1'($urandom);
                bus.imem_data = 8'($urandom);
            end
        end
        m_retired = m_retired + 8'd1;
`ifdef SEQ_SINGLE_STEP_EN
        @(negedge clk);
        check("step_idle", {29'h0, bus.state}, {29'h0, S_IDLE});
`endif
    endtask

    initial begin
        int         lat, rw_n, mw_n, neg_n;
        logic [7:0] pc_vec;
        logic [7:0] ins;

        tbl[0] = '{8'hD6, 4, V_PCW, 1, 0, 0};
        tbl[1] = '{8'hE4, 4, V_PCW, 1, 0, 1};
        tbl[2] = '{8'hC0, 3, V_PCW, 0, 0, 0};
        tbl[3] = '{8'hF7, 3, V_PCW, 0, 0, 0};
        tbl[4] = '{8'h5B, 4 + DMEM_LAT, V_PCW, 1, 0, 0};
        tbl[5] = '{8'h9E, 4, V_PCW, 0, 1, 0};
        tbl[6] = '{8'h3E, 3, V_PCJ, 0, 0, 0};

        // Reset held with ack asserted
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hD6;
        m_retired     = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check("rst_state", {29'h0, bus.state}, {29'h0, S_IDLE});
            check("rst_strobes", {24'h0, obs}, 32'h0);
            check("rst_retired", {24'h0, bus.retired}, 32'h0);
            check("rst_ir", {24'h0, bus.ir}, 32'h0);
            check("rst_fault", {31'h0, bus.fault}, 32'h0);
        end
        areset       = 1'b1;
        bus.imem_ack = 1'b0;
        @(posedge clk); #1;
        check("release_fetch", {29'h0, bus.state}, {29'h0, S_FETCH});
        check("release_req", {31'h0, bus.imem_req}, 32'h1);

        // Table-driven per-class vectors, immediate ack
        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i].ins, 0, lat, pc_vec, rw_n, mw_n, neg_n);
            check("tbl_latency", lat, tbl[i].lat);
            check("tbl_pc_vec", {24'h0, pc_vec}, {24'h0, tbl[i].pc_vec});
            check("tbl_rw_cnt", rw_n, tbl[i].rw);
            check("tbl_mw_cnt", mw_n, tbl[i].mw);
            check("tbl_neg_cnt", neg_n, tbl[i].neg);
        end

        // Ack arriving on the last cycle before the timeout still fetches
        run_instr(8'hD6, FETCH_WAIT_MAX - 1, lat, pc_vec, rw_n, mw_n, neg_n);
        check("ack_at_limit_lat", lat, 4);

        // Random program with random fetch stalls
        repeat (150) begin
            ins = 8'($urandom);
            run_instr(ins, $urandom_range(0, FETCH_WAIT_MAX - 1), lat, pc_vec, rw_n, mw_n, neg_n);
        end

        // Reset during a load's MEM phase discards the instruction
        @(negedge clk);
        check("ld_fetch", {31'h0, bus.imem_req}, 32'h1);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'h5B;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        @(negedge clk);
        check("ld_mem", {24'h0, obs}, {24'h0, V_IMM});
        areset = 1'b0;
        @(negedge clk);
        check("ld_rst_state", {29'h0, bus.state}, {29'h0, S_IDLE});
        check("ld_rst_no_wb", {24'h0, obs}, 32'h0);
        check("ld_rst_retired", {24'h0, bus.retired}, 32'h0);
        m_retired = 8'd0;
        areset    = 1'b1;
        @(posedge clk); #1;
        check("ld_rst_refetch", {29'h0, bus.state}, {29'h0, S_FETCH});

        // 256 NOPs wrap the retired counter
        for (int i = 0; i < 256; i++) begin
            ins = {2'b11, ((i % 2) == 1) ? 2'b11 : 2'b00, 4'($urandom)};
            run_instr(ins, 0, lat, pc_vec, rw_n, mw_n, neg_n);
        end
        @(posedge clk); #1;
        check("retired_wrap", {24'h0, bus.retired}, 32'h0);

        // Fetch timeout
        for (int k = 0; k < FETCH_WAIT_MAX; k++) begin
            @(negedge clk);
            check("to_fetch", {29'h0, bus.state}, {29'h0, S_FETCH});
            bus.imem_ack = 1'b0;
        end
        repeat (5) begin
            @(negedge clk);
            check("halt_state", {29'h0, bus.state}, {29'h0, S_HALT});
            check("halt_fault", {31'h0, bus.fault}, 32'h1);
            check("halt_strobes", {24'h0, obs}, 32'h0);
            bus.imem_ack  = 1'b1;
            bus.imem_data = 8'($urandom);
        end
        areset       = 1'b0;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check("halt_rst_state", {29'h0, bus.state}, {29'h0, S_IDLE});
        check("halt_rst_fault", {31'h0, bus.fault}, 32'h0);
        areset    = 1'b1;
        m_retired = 8'd0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("nostep_idle", {29'h0, bus.state}, {29'h0, S_IDLE});
        end
        step = 1'b1;
`endif
        @(posedge clk); #1;
        check("recover_fetch", {29'h0, bus.state}, {29'h0, S_FETCH});
        run_instr(8'h9E, 0, lat, pc_vec, rw_n, mw_n, neg_n);
        check("recover_mw", mw_n, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
